// File: rtl/bitonic_sort_pkg.sv
// bitonic_sort_pkg: shared constants, FSM encoding and compare-exchange schedule for the 8-element sequential bitonic sorter
package bitonic_sort_pkg;
  localparam int NUM_ELEMS = 8;
  localparam int NUM_STEPS = 12;
  localparam logic U = 1'b0;
  localparam logic D = 1'b1;
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  typedef struct packed {
    logic [2:0] lo;
    logic [2:0] hi;
    logic       dir;
  } pair_t;
  // dir U: lower index gets the min; dir D: lower index gets the max
  localparam pair_t SCHEDULE [6][4] = '{
    '{'{3'd0, 3'd1, U}, '{3'd2, 3'd3, D}, '{3'd4, 3'd5, U}, '{3'd6, 3'd7, D}},
    '{'{3'd0, 3'd2, U}, '{3'd1, 3'd3, U}, '{3'd4, 3'd6, D}, '{3'd5, 3'd7, D}},
    '{'{3'd0, 3'd1, U}, '{3'd2, 3'd3, U}, '{3'd4, 3'd5, D}, '{3'd6, 3'd7, D}},
    '{'{3'd0, 3'd4, U}, '{3'd1, 3'd5, U}, '{3'd2, 3'd6, U}, '{3'd3, 3'd7, U}},
    '{'{3'd0, 3'd2, U}, '{3'd1, 3'd3, U}, '{3'd4, 3'd6, U}, '{3'd5, 3'd7, U}},
    '{'{3'd0, 3'd1, U}, '{3'd2, 3'd3, U}, '{3'd4, 3'd5, U}, '{3'd6, 3'd7, U}}
  };
endpackage

// File: rtl/bitonic_cmp_swap.sv
// bitonic_cmp_swap: combinational compare-exchange lane; equal values are never swapped
module bitonic_cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dir,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic swap;
  assign swap = dir ? (a < b) : (a > b);
  assign lo = swap ? b : a;
  assign hi = swap ? a : b;
endmodule

// File: rtl/bitonic_sort_seq_8.sv
// bitonic_sort_seq_8: sequential 8-element ascending bitonic sorter, two compare-exchanges per cycle over 12 steps
module bitonic_sort_seq_8
  import bitonic_sort_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_ELEMS*WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_ELEMS*WIDTH-1:0] out_data,
  output logic                       busy
);
  state_t state, next_state;
  logic [3:0] step;
  logic [WIDTH-1:0] elem [NUM_ELEMS];
  pair_t p0, p1;
  logic [WIDTH-1:0] lo0, hi0, lo1, hi1;
  logic last_step;
  assign p0 = SCHEDULE[step[3:1]][{step[0], 1'b0}];
  assign p1 = SCHEDULE[step[3:1]][{step[0], 1'b1}];
  assign last_step = step == 4'(NUM_STEPS - 1);
  bitonic_cmp_swap #(.WIDTH(WIDTH)) u_lane0 (
    .a(elem[p0.lo]), .b(elem[p0.hi]), .dir(p0.dir), .lo(lo0), .hi(hi0)
  );
  bitonic_cmp_swap #(.WIDTH(WIDTH)) u_lane1 (
    .a(elem[p1.lo]), .b(elem[p1.hi]), .dir(p1.dir), .lo(lo1), .hi(hi1)
  );
  always_comb begin
    next_state = (state == IDLE && in_valid)  ? SORT :
                 (state == SORT && last_step) ? DONE :
                 (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      for (int i = 0; i < NUM_ELEMS; i++) elem[i] <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && in_valid) begin
        for (int i = 0; i < NUM_ELEMS; i++) elem[i] <= in_data[i*WIDTH +: WIDTH];
        step <= '0;
      end else if (state == SORT) begin
        elem[p0.lo] <= lo0;
        elem[p0.hi] <= hi0;
        elem[p1.lo] <= lo1;
        elem[p1.hi] <= hi1;
        step <= last_step ? '0 : step + 4'd1;
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == SORT;
  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = elem[g];
  end
endmodule

// File: tb/tb_bitonic_sort_seq_8.sv
// tb_bitonic_sort_seq_8: directed vectors with a scoreboard queue popped by an independent output monitor
module tb_bitonic_sort_seq_8;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_data;
  int errors = 0, checks = 0, cyc = 0, acc_edge = -100, prev_acc = -1, busy_cnt = 0, n_out = 0;
  bit cont = 0, prev_ov = 0;
  logic [63:0] exp_q [$];
  logic [63:0] cont_in  [4] = '{64'h50463C32_281E140A, 64'h02020808_01010909,
                                64'h2010FF00_FE017F80, 64'h04070209_01080305};
  logic [63:0] cont_exp [4] = '{64'h50463C32_281E140A, 64'h09090808_02020101,
                                64'hFFFE807F_20100100, 64'h09080705_04030201};

  bitonic_sort_seq_8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop, latency, busy duration and accept spacing
  always @(negedge clk) begin
    if (rst) prev_ov = 0;
    else begin
      if (busy) busy_cnt++;
      if (out_valid && !prev_ov) begin
        chk("latency", 64'(cyc - acc_edge), 64'd12);
        chk("busy_cycles", 64'(busy_cnt), 64'd12);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else chk("sorted", out_data, exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        if (cont && prev_acc >= 0) chk("accept_gap", 64'(cyc + 1 - prev_acc), 64'd14);
        prev_acc = cyc + 1;
        acc_edge = cyc + 1;
        busy_cnt = 0;
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send(input logic [63:0] vin, input logic [63:0] vexp);
    wait_ready();
    in_data  = vin;
    in_valid = 1;
    exp_q.push_back(vexp);
    tick();
    in_valid = 0;
  endtask

  initial begin
    int n;
    repeat (2) tick();
    rst = 0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    out_ready = 1;
    send(64'h00010203_04050607, 64'h07060504_03020100);
    wait_ready();
    send(64'h55555555_55555555, 64'h55555555_55555555);
    wait_ready();
    // Backpressure: hold DONE for 5 cycles, in_valid pulse must be ignored
    out_ready = 0;
    send(64'h00FF00FF_01030103, 64'hFFFF0303_01010000);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_out_data", out_data, 64'hFFFF0303_01010000);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      in_valid = (i == 2);
      in_data  = 64'hDEADBEEF_CAFEF00D;
      tick();
    end
    in_valid = 0;
    chk("hold_after_pulse", 64'(out_valid), 64'd1);
    out_ready = 1;
    wait_ready();
    // Reset mid-sort at step 5
    send(64'h11335577_00224466, 64'h77665544_33221100);
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    exp_q.delete();
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    send(64'h11335577_00224466, 64'h77665544_33221100);
    wait_ready();
    // Continuous streaming with in_valid and out_ready held high
    cont = 1;
    prev_acc = -1;
    for (int k = 0; k < 4; k++) begin
      wait_ready();
      in_data  = cont_in[k];
      in_valid = 1;
      exp_q.push_back(cont_exp[k]);
      tick();
    end
    in_valid = 0;
    wait_ready();
    cont = 0;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("output_count", 64'(n_out), 64'd8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
